// File: rtl/gamectl_pkg.sv
// Shared encodings and limits for the ballplayer round controller.
package gamectl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_ARM      = 3'd2,
        ST_PLAY     = 3'd3,
        ST_LOST     = 3'd4,
        ST_GAMEOVER = 3'd5
    } state_t;

    localparam logic [9:0] MAX_SCORE = 10'd999;
    localparam logic [1:0] MAX_LEVEL = 2'd3;

endpackage

// File: rtl/game_round_ctrl_if.sv
// Button / ball-motion / display bundle around the round controller.
interface game_round_ctrl_if;

    logic       start_btn;
    logic       bounce_evt;
    logic       over_flag;
    logic       serve_n;
    logic [1:0] k;
    logic [8:0] home;
    logic [9:0] score;
    logic [1:0] lives;
    logic [1:0] level;
    logic       game_over;
    logic [2:0] state_o;

    modport master (
        input  start_btn, bounce_evt, over_flag,
        output serve_n, k, home, score, lives, level, game_over, state_o
    );

    modport slave (
        output start_btn, bounce_evt, over_flag,
        input  serve_n, k, home, score, lives, level, game_over, state_o
    );

endinterface

// File: rtl/game_round_ctrl_rise_detect.sv
// Rising-edge detector with an optional extra synchroniser flop for truly asynchronous inputs.
module rise_detect #(
    parameter int SYNC = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sync_p0;
    logic lvl_p1;
    logic lvl_p2;

    generate
        if (SYNC != 0) begin : g_sync
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_p0 <= 1'b0;
                else     sync_p0 <= din;
            end
        end else begin : g_direct
            assign sync_p0 = din;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_p1 <= 1'b0;
            lvl_p2 <= 1'b0;
        end else begin
            lvl_p1 <= sync_p0;
            lvl_p2 <= lvl_p1;
        end
    end

    assign rise = lvl_p1 & ~lvl_p2;

endmodule

// File: rtl/game_round_ctrl.sv
// Round/scoring sequencer: serves the ball, counts bounces, tracks lives and level, flags game over.
module game_round_ctrl
    import gamectl_pkg::*;
#(
    parameter int         LIVES         = 3,
    parameter int         SERVE_CYC     = 16,
    parameter int         ARM_TIMEOUT   = 4096,
    parameter int         CATCH_PER_LVL = 8,
    parameter logic [8:0] HOME_Y        = 9'd20
) (
    input logic             clk,
    input logic             rst,
    game_round_ctrl_if.master bus
);

    localparam int SRV_W = $clog2(SERVE_CYC);
    localparam int ARM_W = $clog2(ARM_TIMEOUT);
    localparam int CAT_W = $clog2(CATCH_PER_LVL);

    localparam logic [SRV_W-1:0] SRV_LAST = SRV_W'(SERVE_CYC - 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);
    localparam logic [CAT_W-1:0] CAT_LAST = CAT_W'(CATCH_PER_LVL - 1);
    localparam logic [1:0]       LIVES_L  = 2'(LIVES);

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v >= MAX_SCORE) ? MAX_SCORE : v + 10'd1;
    endfunction

    logic start_rise, bounce_rise, over_rise;
    logic over_lvl;

    state_t           state,     state_nx;
    logic [SRV_W-1:0] serve_cnt, serve_cnt_nx;
    logic [ARM_W-1:0] arm_cnt,   arm_cnt_nx;
    logic [CAT_W-1:0] catch_cnt, catch_cnt_nx;
    logic [9:0]       score,     score_nx;
    logic [1:0]       lives,     lives_nx;
    logic [1:0]       level,     level_nx;
    logic             game_over, game_over_nx;
    logic             serve_n;
    logic [1:0]       k;

    rise_detect #(.SYNC(1)) u_start  (.clk(clk), .rst(rst), .din(bus.start_btn),  .rise(start_rise));
    rise_detect #(.SYNC(0)) u_bounce (.clk(clk), .rst(rst), .din(bus.bounce_evt), .rise(bounce_rise));
    rise_detect #(.SYNC(0)) u_over   (.clk(clk), .rst(rst), .din(bus.over_flag),  .rise(over_rise));

    // ARM needs the settled level of over_flag, not just its edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) over_lvl <= 1'b0;
        else     over_lvl <= bus.over_flag;
    end

    always_comb begin
        state_nx     = state;
        serve_cnt_nx = serve_cnt;
        arm_cnt_nx   = arm_cnt;
        catch_cnt_nx = catch_cnt;
        score_nx     = score;
        lives_nx     = lives;
        level_nx     = level;
        game_over_nx = game_over;
        case (state)
            ST_IDLE, ST_GAMEOVER: begin
                if (start_rise) begin
                    score_nx     = '0;
                    lives_nx     = LIVES_L;
                    level_nx     = '0;
                    catch_cnt_nx = '0;
                    game_over_nx = 1'b0;
                    serve_cnt_nx = '0;
                    state_nx     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (serve_cnt == SRV_LAST) begin
                    serve_cnt_nx = '0;
                    arm_cnt_nx   = '0;
                    state_nx     = ST_ARM;
                end else begin
                    serve_cnt_nx = serve_cnt + 1'b1;
                end
            end
            ST_ARM: begin
                if (!over_lvl) begin
                    state_nx = ST_PLAY;
                end else if (arm_cnt == ARM_LAST) begin
                    arm_cnt_nx   = '0;
                    serve_cnt_nx = '0;
                    state_nx     = ST_SERVE;
                end else begin
                    arm_cnt_nx = arm_cnt + 1'b1;
                end
            end
            ST_PLAY: begin
                // a lost ball in the same cycle as a bounce discards the bounce
                if (over_rise) begin
                    state_nx = ST_LOST;
                end else if (bounce_rise) begin
                    score_nx = sat_inc(score);
                    if (catch_cnt == CAT_LAST) begin
                        catch_cnt_nx = '0;
                        if (level != MAX_LEVEL) level_nx = level + 2'd1;
                    end else begin
                        catch_cnt_nx = catch_cnt + 1'b1;
                    end
                end
            end
            ST_LOST: begin
                if (lives <= 2'd1) begin
                    lives_nx     = '0;
                    game_over_nx = 1'b1;
                    state_nx     = ST_GAMEOVER;
                end else begin
                    lives_nx     = lives - 2'd1;
                    serve_cnt_nx = '0;
                    state_nx     = ST_SERVE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            serve_cnt <= '0;
            arm_cnt   <= '0;
            catch_cnt <= '0;
            score     <= '0;
            lives     <= '0;
            level     <= '0;
            game_over <= 1'b0;
            serve_n   <= 1'b1;
            k         <= MAX_LEVEL;
        end else begin
            state     <= state_nx;
            serve_cnt <= serve_cnt_nx;
            arm_cnt   <= arm_cnt_nx;
            catch_cnt <= catch_cnt_nx;
            score     <= score_nx;
            lives     <= lives_nx;
            level     <= level_nx;
            game_over <= game_over_nx;
            serve_n   <= (state_nx != ST_SERVE);
            k         <= MAX_LEVEL - level_nx;
        end
    end

    assign bus.serve_n   = serve_n;
    assign bus.k         = k;
    assign bus.home      = HOME_Y;
    assign bus.score     = score;
    assign bus.lives     = lives;
    assign bus.level     = level;
    assign bus.game_over = game_over;
    assign bus.state_o   = state;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomized bench for game_round_ctrl against a game-level scoring model.
module tb_game_round_ctrl;

    localparam int SERVE_CYC   = 16;
    localparam int ARM_TIMEOUT = 4096;
    localparam int CPL         = 8;
    localparam int S_IDLE = 0, S_SERVE = 1, S_ARM = 2, S_PLAY = 3, S_LOST = 4, S_GO = 5;

    logic clk = 1'b0;
    logic rst;
    game_round_ctrl_if bus();

    game_round_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // game-level model: level follows total bounces this game, score saturates
    int m_score, m_lives, m_bounces, m_over;

    function automatic int m_level();
        return (m_bounces / CPL > 3) ? 3 : m_bounces / CPL;
    endfunction

    task automatic m_new_game();
        m_score = 0; m_lives = 3; m_bounces = 0; m_over = 0;
    endtask

    task automatic m_bounce();
        if (m_score < 999) m_score++;
        m_bounces++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".score"},     32'(bus.score),     32'(m_score));
        chk({tag, ".lives"},     32'(bus.lives),     32'(m_lives));
        chk({tag, ".level"},     32'(bus.level),     32'(m_level()));
        chk({tag, ".k"},         32'(bus.k),         32'(3 - m_level()));
        chk({tag, ".game_over"}, 32'(bus.game_over), 32'(m_over));
    endtask

    task automatic pulse_bounce();
        bus.bounce_evt = 1'b1;
        tick($urandom_range(1, 3));
        bus.bounce_evt = 1'b0;
        tick($urandom_range(2, 3));
    endtask

    task automatic press_start(input int n);
        bus.start_btn = 1'b1;
        fork
            begin
                tick(n);
                bus.start_btn = 1'b0;
            end
        join_none
    endtask

    task automatic wait_serve(input string tag);
        int guard = 0;
        int lows  = 0;
        while (bus.serve_n !== 1'b0 && guard < 6000) begin
            tick();
            guard++;
        end
        chk({tag, ".serve_seen"}, 32'(guard < 6000), 32'd1);
        if (guard < 6000) begin
            chk({tag, ".state_serve"}, 32'(bus.state_o), S_SERVE);
            while (bus.serve_n === 1'b0 && lows < 100) begin
                lows++;
                tick();
            end
            chk({tag, ".serve_len"}, lows, SERVE_CYC);
        end
    endtask

    task automatic enter_play(input string tag);
        tick();
        chk({tag, ".state_play"}, 32'(bus.state_o), S_PLAY);
    endtask

    task automatic lose(input string tag, input bit with_bounce);
        bus.over_flag = 1'b1;
        if (with_bounce) bus.bounce_evt = 1'b1;
        tick(2);
        chk({tag, ".state_lost"}, 32'(bus.state_o), S_LOST);
        chk({tag, ".score_lost"}, 32'(bus.score), 32'(m_score));
        bus.bounce_evt = 1'b0;
        if (m_lives == 1) begin
            m_lives = 0;
            m_over  = 1;
            tick();
            chk({tag, ".state_go"}, 32'(bus.state_o), S_GO);
            chk_all({tag, ".go"});
        end else begin
            m_lives--;
        end
    endtask

    initial begin
        int n;
        int falls;
        logic prev;

        bus.start_btn  = 1'b0;
        bus.bounce_evt = 1'b0;
        bus.over_flag  = 1'b0;
        rst = 1'b1;
        tick(3);
        chk("rst.serve_n",   32'(bus.serve_n),   32'd1);
        chk("rst.k",         32'(bus.k),         32'd3);
        chk("rst.home",      32'(bus.home),      32'd20);
        chk("rst.score",     32'(bus.score),     32'd0);
        chk("rst.lives",     32'(bus.lives),     32'd0);
        chk("rst.level",     32'(bus.level),     32'd0);
        chk("rst.game_over", 32'(bus.game_over), 32'd0);
        chk("rst.state",     32'(bus.state_o),   S_IDLE);
        rst = 1'b0;
        tick(4);
        chk("idle.state", 32'(bus.state_o), S_IDLE);

        // new game, then level ramp through all three steps
        press_start(5);
        wait_serve("t1");
        enter_play("t1");
        m_new_game();
        chk_all("t1");
        repeat (8) begin pulse_bounce(); m_bounce(); end
        chk_all("t2.lvl1");
        repeat (24) begin pulse_bounce(); m_bounce(); end
        chk_all("t2.lvl3");
        repeat (8) begin pulse_bounce(); m_bounce(); end
        chk_all("t2.hold");

        // lose all lives with random play in between
        repeat (2) begin
            repeat ($urandom_range(0, 4)) begin pulse_bounce(); m_bounce(); end
            lose("t3", 1'b0);
            bus.over_flag = 1'b0;
            wait_serve("t3");
            enter_play("t3");
            chk_all("t3.play");
        end
        lose("t3.last", 1'b0);
        bus.over_flag = 1'b0;
        pulse_bounce();
        chk("go.score_held", 32'(bus.score), 32'(m_score));
        tick(3);
        chk("go.state_held", 32'(bus.state_o), S_GO);

        // restart from game over, then simultaneous bounce/loss
        press_start($urandom_range(1, 8));
        wait_serve("t4");
        enter_play("t4");
        m_new_game();
        chk_all("t4.new");
        repeat (5) begin pulse_bounce(); m_bounce(); end
        chk("t4.score5", 32'(bus.score), 32'd5);
        lose("t4", 1'b1);

        // ball never settles: ARM times out and re-serves
        wait_serve("t5.first");
        n = 0;
        while (bus.serve_n === 1'b1 && n < 5000) begin
            n++;
            tick();
        end
        chk("t5.arm_wait", n, ARM_TIMEOUT);
        bus.over_flag = 1'b0;
        wait_serve("t5.second");
        enter_play("t5");
        chk_all("t5.play");
        while (m_score < 998) begin
            bus.bounce_evt = 1'b1;
            tick($urandom_range(1, 2));
            bus.bounce_evt = 1'b0;
            tick($urandom_range(1, 2));
            m_bounce();
        end
        tick(2);
        chk_all("t5.s998");
        repeat (3) begin pulse_bounce(); m_bounce(); end
        chk_all("t5.s999");

        // reset in the middle of a serve
        lose("t6", 1'b0);
        bus.over_flag = 1'b0;
        tick(5);
        chk("t6.pre_serve_n", 32'(bus.serve_n), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("t6.serve_n",   32'(bus.serve_n),   32'd1);
        chk("t6.score",     32'(bus.score),     32'd0);
        chk("t6.lives",     32'(bus.lives),     32'd0);
        chk("t6.level",     32'(bus.level),     32'd0);
        chk("t6.k",         32'(bus.k),         32'd3);
        chk("t6.state",     32'(bus.state_o),   S_IDLE);
        tick();
        rst = 1'b0;
        tick(3);

        // start held for 1000 clocks must serve only once
        bus.start_btn = 1'b1;
        falls = 0;
        prev  = bus.serve_n;
        for (int i = 0; i < 1100; i++) begin
            if (i == 1000) bus.start_btn = 1'b0;
            tick();
            if (prev === 1'b1 && bus.serve_n === 1'b0) falls++;
            prev = bus.serve_n;
        end
        chk("t6.one_serve", falls, 32'd1);
        chk("t6.state_play", 32'(bus.state_o), S_PLAY);
        m_new_game();
        chk_all("t6.new");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
